// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment capture path: segment encodings,
// capture state type and index-width helper.
package sseg_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/sseg_decoder.sv
// Combinational segment-pattern to hex decoder; legal=0 for any pattern
// outside the sixteen hex glyphs.
module sseg_decoder
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] hex
);

  always_comb begin
    legal = 1'b1;
    hex   = 4'h0;
    case (seg)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: begin
        legal = 1'b0;
        hex   = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/sseg_capture.sv
// Observes the multiplexed anode/segment bus, rebuilds the displayed digits
// and flags malformed anodes, illegal glyphs and out-of-order scanning.
module sseg_capture
  import sseg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic [DIGITS-1:0]     digit_ok,
  output logic                  frame_done,
  output logic                  err_an,
  output logic                  err_seq,
  output logic                  err_seg
);

  localparam int IW = idx_width(DIGITS);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DIGITS-1:0]   an_prev_q, an_prev_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  state_e              state_q, state_d;
  logic [IW-1:0]       exp_q, exp_d;
  logic                in_frame_q, in_frame_d;
  logic                first_q, first_d;
  logic [4*DIGITS-1:0] digit_val_q, digit_val_d;
  logic [DIGITS-1:0]   digit_ok_q, digit_ok_d;
  logic                frame_done_q, frame_done_d;
  logic                err_an_q, err_an_d;
  logic                err_seq_q, err_seq_d;
  logic                err_seg_q, err_seg_d;

  logic                seen_s, multi_s, one_zero_s, capture_s;
  logic [IW-1:0]       idx_s;
  logic                dec_legal_s;
  logic [3:0]          dec_hex_s;

  sseg_decoder u_dec (
    .seg   (seg),
    .legal (dec_legal_s),
    .hex   (dec_hex_s)
  );

  // Anode decode: lowest zero gives the index, a second zero marks it malformed
  always_comb begin
    seen_s  = 1'b0;
    multi_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      multi_s = multi_s | (seen_s & ~an[i]);
      if (!an[i] && !seen_s) begin
        idx_s = IW'(i);
      end else begin
        idx_s = idx_s;
      end
      seen_s = seen_s | ~an[i];
    end
    one_zero_s = seen_s & ~multi_s;
  end

  // Settle counter and WAIT/CAPTURE/HOLD sequencing
  always_comb begin
    an_prev_d = an;
    cnt_d     = cnt_q;
    state_d   = state_q;
    if (an != an_prev_q) begin
      cnt_d   = '0;
      state_d = WAIT;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
      case (state_q)
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = CAPTURE;
          end else begin
            state_d = WAIT;
          end
        end
        CAPTURE: state_d = HOLD;
        HOLD:    state_d = HOLD;
        default: state_d = WAIT;
      endcase
    end
    capture_s = (state_d == CAPTURE);
  end

  // Digit write-back, ring-order tracking and sticky error flags
  always_comb begin
    digit_val_d  = digit_val_q;
    digit_ok_d   = digit_ok_q;
    frame_done_d = 1'b0;
    err_an_d     = err_an_q;
    err_seq_d    = err_seq_q;
    err_seg_d    = err_seg_q;
    exp_d        = exp_q;
    in_frame_d   = in_frame_q;
    first_d      = first_q;
    if (capture_s) begin
      if (one_zero_s) begin
        digit_val_d[4*idx_s +: 4] = dec_legal_s ? dec_hex_s : 4'h0;
        digit_ok_d[idx_s]         = dec_legal_s;
        if (!dec_legal_s) begin
          err_seg_d = 1'b1;
        end else begin
          err_seg_d = err_seg_q;
        end
        first_d = 1'b0;
        // Digit 0 always (re)opens a frame; the very first capture never errors
        if (idx_s == '0) begin
          exp_d      = IW'(1);
          in_frame_d = 1'b1;
        end else if (first_q) begin
          in_frame_d = 1'b0;
        end else if (in_frame_q && (idx_s == exp_q)) begin
          if (idx_s == IDX_LAST) begin
            frame_done_d = 1'b1;
            in_frame_d   = 1'b0;
            exp_d        = '0;
          end else begin
            exp_d = exp_q + IW'(1);
          end
        end else begin
          err_seq_d  = 1'b1;
          in_frame_d = 1'b0;
        end
      end else begin
        err_an_d = 1'b1;
      end
    end else begin
      frame_done_d = 1'b0;
    end
    if (clr) begin
      err_an_d     = 1'b0;
      err_seq_d    = 1'b0;
      err_seg_d    = 1'b0;
      in_frame_d   = 1'b0;
      exp_d        = '0;
      first_d      = 1'b1;
      frame_done_d = 1'b0;
    end else begin
      first_d = first_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_prev_q    <= '1;
      cnt_q        <= '0;
      state_q      <= WAIT;
      exp_q        <= '0;
      in_frame_q   <= 1'b0;
      first_q      <= 1'b1;
      digit_val_q  <= '0;
      digit_ok_q   <= '0;
      frame_done_q <= 1'b0;
      err_an_q     <= 1'b0;
      err_seq_q    <= 1'b0;
      err_seg_q    <= 1'b0;
    end else begin
      an_prev_q    <= an_prev_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      exp_q        <= exp_d;
      in_frame_q   <= in_frame_d;
      first_q      <= first_d;
      digit_val_q  <= digit_val_d;
      digit_ok_q   <= digit_ok_d;
      frame_done_q <= frame_done_d;
      err_an_q     <= err_an_d;
      err_seq_q    <= err_seq_d;
      err_seg_q    <= err_seg_d;
    end
  end

  assign digit_val  = digit_val_q;
  assign digit_ok   = digit_ok_q;
  assign frame_done = frame_done_q;
  assign err_an     = err_an_q;
  assign err_seq    = err_seq_q;
  assign err_seg    = err_seg_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Scoreboard bench for sseg_capture: a run-length reference model predicts
// every cycle's outputs, a negedge monitor compares them.
module tb_sseg_capture;

  localparam int DIGITS = 4;
  localparam int SETTLE = 2;
  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    logic [15:0] dv;
    logic [3:0]  ok;
    logic        fd;
    logic        ea;
    logic        eq;
    logic        es;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hE;
  logic [6:0]  seg = 7'h40;
  logic        clr = 1'b0;
  logic [15:0] digit_val;
  logic [3:0]  digit_ok;
  logic        frame_done, err_an, err_seq, err_seg;

  sseg_capture #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .clr(clr),
    .digit_val(digit_val), .digit_ok(digit_ok), .frame_done(frame_done),
    .err_an(err_an), .err_seq(err_seq), .err_seg(err_seg)
  );

  always #5 clk = ~clk;

  snap_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int fd_seen = 0;

  // Reference model: run length of the sampled anode value decides capture
  logic [3:0] m_prev;
  int         m_run;
  logic [3:0] m_val [4];
  logic [3:0] m_ok;
  logic       m_fd, m_ea, m_eq, m_es, m_in, m_first;
  int         m_exp;

  task automatic m_reset();
    m_prev = 4'hF; m_run = 0; m_ok = 4'h0;
    for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
    m_fd = 1'b0; m_ea = 1'b0; m_eq = 1'b0; m_es = 1'b0;
    m_in = 1'b0; m_first = 1'b1; m_exp = 0;
  endtask

  function automatic snap_t m_snap();
    snap_t s;
    s.dv = {m_val[3], m_val[2], m_val[1], m_val[0]};
    s.ok = m_ok; s.fd = m_fd; s.ea = m_ea; s.eq = m_eq; s.es = m_es;
    return s;
  endfunction

  task automatic m_edge(input logic [3:0] a, input logic [6:0] s, input logic c);
    int zeros, idx, hex;
    bit legal;
    m_fd = 1'b0;
    if (a == m_prev) m_run++; else m_run = 0;
    m_prev = a;
    if (m_run == SETTLE) begin
      zeros = 0; idx = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; idx = i; end
      if (zeros != 1) begin
        m_ea = 1'b1;
      end else begin
        legal = 1'b0; hex = 0;
        for (int h = 0; h < 16; h++) if (SEG_TAB[h] == s) begin legal = 1'b1; hex = h; end
        m_val[idx] = legal ? 4'(hex) : 4'h0;
        m_ok[idx]  = legal;
        if (!legal) m_es = 1'b1;
        if (idx == 0) begin
          m_exp = 1; m_in = 1'b1;
        end else if (m_first) begin
          m_in = 1'b0;
        end else if (m_in && idx == m_exp) begin
          if (idx == DIGITS - 1) begin m_fd = 1'b1; m_in = 1'b0; m_exp = 0; end
          else m_exp++;
        end else begin
          m_eq = 1'b1; m_in = 1'b0;
        end
        m_first = 1'b0;
      end
    end
    if (c) begin
      m_ea = 1'b0; m_eq = 1'b0; m_es = 1'b0;
      m_in = 1'b0; m_exp = 0; m_first = 1'b1; m_fd = 1'b0;
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic c, input int n);
    repeat (n) begin
      an = a; seg = s; clr = c;
      @(posedge clk);
      if (!rst_n) m_reset(); else m_edge(a, s, c);
      exp_q.push_back(m_snap());
      #1;
    end
  endtask

  task automatic hold(input int d, input logic [6:0] s, input int n);
    drive(4'hF ^ (4'h1 << d), s, 1'b0, n);
  endtask

  task automatic clean_scan();
    hold(0, 7'h30, 8); hold(1, 7'h24, 8); hold(2, 7'h79, 8); hold(3, 7'h40, 8);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare every cycle's outputs with the model's prediction
  always @(negedge clk) begin
    snap_t e, act;
    if (frame_done === 1'b1) fd_seen++;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {digit_val, digit_ok, frame_done, err_an, err_seq, err_seg};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t actual dv=%h ok=%h fd/ea/eq/es=%b required dv=%h ok=%h fd/ea/eq/es=%b",
                 $time, act.dv, act.ok, {act.fd, act.ea, act.eq, act.es},
                 e.dv, e.ok, {e.fd, e.ea, e.eq, e.es});
      end
    end
  end

  initial begin
    int fd0, d, kind, n, w;
    logic [3:0] a;
    logic [6:0] s;

    m_reset();
    drive(4'hE, 7'h30, 1'b0, 3);
    check("reset_state", 32'({digit_val, digit_ok, frame_done, err_an, err_seq, err_seg}), 32'h0);
    rst_n = 1'b1;

    fd0 = fd_seen;
    clean_scan(); clean_scan();
    check("clean_val", 32'(digit_val), 32'h0123);
    check("clean_ok", 32'(digit_ok), 32'hF);
    check("clean_frames", 32'(fd_seen - fd0), 32'd2);
    check("clean_errs", 32'({err_an, err_seq, err_seg}), 32'h0);

    fd0 = fd_seen;
    hold(0, 7'h30, 3); hold(1, 7'h24, 1); hold(0, 7'h30, 4);
    hold(1, 7'h24, 8); hold(2, 7'h79, 8); hold(3, 7'h40, 8);
    check("glitch_val", 32'(digit_val), 32'h0123);
    check("glitch_seq", 32'(err_seq), 32'h0);
    check("glitch_frames", 32'(fd_seen - fd0), 32'd1);

    drive(4'hC, 7'h40, 1'b0, 4);
    check("bad_an_flag", 32'(err_an), 32'h1);
    check("bad_an_val", 32'(digit_val), 32'h0123);
    drive(4'hC, 7'h40, 1'b1, 1);
    check("bad_an_clr", 32'(err_an), 32'h0);

    hold(0, 7'h30, 8); hold(1, 7'h24, 8); hold(2, 7'h7F, 8); hold(3, 7'h40, 8);
    check("illegal_ok", 32'(digit_ok), 32'hB);
    check("illegal_val", 32'(digit_val), 32'h0023);
    check("illegal_flag", 32'(err_seg), 32'h1);
    drive(4'h7, 7'h40, 1'b1, 1);
    check("illegal_clr", 32'(err_seg), 32'h0);

    fd0 = fd_seen;
    hold(0, 7'h30, 8); hold(2, 7'h79, 8); hold(1, 7'h24, 8); hold(3, 7'h40, 8);
    check("order_err", 32'(err_seq), 32'h1);
    check("order_no_frame", 32'(fd_seen - fd0), 32'd0);
    fd0 = fd_seen;
    clean_scan();
    check("order_recover", 32'(fd_seen - fd0), 32'd1);

    drive(4'hC, 7'h40, 1'b1, 1);
    hold(0, 7'h30, 8); hold(1, 7'h24, 8);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({digit_val, digit_ok, frame_done, err_an, err_seq, err_seg}), 32'h0);
    m_reset();
    exp_q.delete();
    exp_q.push_back(m_snap());
    drive(4'hD, 7'h24, 1'b0, 2);
    rst_n = 1'b1;
    fd0 = fd_seen;
    hold(1, 7'h24, 8);
    check("post_reset_partial", 32'(fd_seen - fd0), 32'd0);
    clean_scan();
    check("post_reset_frame", 32'(fd_seen - fd0), 32'd1);
    check("post_reset_seq", 32'(err_seq), 32'h0);
    check("post_reset_val", 32'(digit_val), 32'h0123);

    d = 3;
    repeat (300) begin
      kind = $urandom_range(0, 19);
      n = $urandom_range(1, 6);
      s = (kind == 3) ? 7'($urandom_range(0, 127)) : SEG_TAB[$urandom_range(0, 15)];
      if (kind == 2) d = $urandom_range(0, 3); else d = (d + 1) % 4;
      a = 4'hF ^ (4'h1 << d);
      if (kind == 0) a = 4'($urandom_range(0, 15));
      if (kind == 1) begin
        drive(a, s, 1'b1, 1);
        drive(a, s, 1'b0, n);
      end else if (kind == 4) begin
        drive(a, s, 1'b0, SETTLE);
        drive(a, s, 1'b1, 1);
        drive(a, s, 1'b0, n);
      end else begin
        drive(a, s, 1'b0, n);
      end
    end

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d entries left required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
